// File: rtl/inv_s_box_serial_if.sv
// Handshake bundle for the nibble-serial inverse S-box: word input
// channel and result output channel, each with valid/ready.
interface inv_s_box_serial_if #(
   parameter int NIBBLES = 16
);
   logic                   in_valid;
   logic                   in_ready;
   logic [4*NIBBLES-1:0]   in_data;
   logic                   out_valid;
   logic                   out_ready;
   logic [4*NIBBLES-1:0]   out_data;

   // The substitution engine sits on this side
   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   // Upstream source / downstream sink sits on this side
   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/inv_s_box_serial.sv
// Nibble-serial inverse substitution engine. A state word is loaded into a
// shift register, then rotated right one nibble per clock while the nibble
// leaving the bottom passes through a single shared inverse S-box. After
// NIBBLES rotations every nibble is substituted and back in place.
module inv_s_box_serial #(
   parameter int NIBBLES = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   inv_s_box_serial_if.slave    bus,
   output logic                 busy
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    sreg_q,  sreg_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [3:0]      subNib;

   // Single shared inverse S-box applied to the nibble leaving the bottom
   always_comb begin
      subNib = 4'h0;
      case (sreg_q[3:0])
         4'h0: subNib = 4'hA;
         4'h1: subNib = 4'h3;
         4'h2: subNib = 4'h9;
         4'h3: subNib = 4'hE;
         4'h4: subNib = 4'h1;
         4'h5: subNib = 4'hD;
         4'h6: subNib = 4'hF;
         4'h7: subNib = 4'h4;
         4'h8: subNib = 4'hC;
         4'h9: subNib = 4'h5;
         4'hA: subNib = 4'h7;
         4'hB: subNib = 4'h2;
         4'hC: subNib = 4'h6;
         4'hD: subNib = 4'h8;
         4'hE: subNib = 4'h0;
         4'hF: subNib = 4'hB;
         default: subNib = 4'h0;
      endcase
   end

   // Next-state logic: load in IDLE, rotate-and-substitute in RUN,
   // hold the finished word in DONE until the sink takes it
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               sreg_d  = bus.in_data;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sreg_d = {subNib, sreg_q[W-1:4]};
            if (cnt_q == LAST) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, shift register and counter; reset wins over any handshake
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_data  = sreg_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_inv_s_box_serial.sv
// Self-checking bench for inv_s_box_serial: table of known vectors,
// random round trips through an independent forward S-box, plus
// backpressure, held-input and mid-run reset sequences.
module tb_inv_s_box_serial;
   localparam int NIBBLES = 16;
   localparam int W = 4 * NIBBLES;

   logic clk;
   logic rst;
   logic busy;

   inv_s_box_serial_if #(.NIBBLES(NIBBLES)) bus ();

   inv_s_box_serial #(.NIBBLES(NIBBLES)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   typedef struct {
      logic [W-1:0] inWord;
      logic [W-1:0] expWord;
   } vec_t;

   vec_t          vecs[5];
   logic [W-1:0]  expQ[$];
   int            checks = 0;
   int            errors = 0;
   int            popCount = 0;

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so the run can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [W-1:0] actual,
                              input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   function automatic logic [3:0] fwdNib(input logic [3:0] x);
      logic [3:0] r;
      case (x)
         4'h0: r = 4'hE;  4'h1: r = 4'h4;  4'h2: r = 4'hB;  4'h3: r = 4'h1;
         4'h4: r = 4'h7;  4'h5: r = 4'h9;  4'h6: r = 4'hC;  4'h7: r = 4'hA;
         4'h8: r = 4'hD;  4'h9: r = 4'h2;  4'hA: r = 4'h0;  4'hB: r = 4'hF;
         4'hC: r = 4'h8;  4'hD: r = 4'h5;  4'hE: r = 4'h3;  default: r = 4'h6;
      endcase
      return r;
   endfunction

   function automatic logic [W-1:0] fwdWord(input logic [W-1:0] x);
      logic [W-1:0] r;
      for (int i = 0; i < NIBBLES; i++) r[4*i +: 4] = fwdNib(x[4*i +: 4]);
      return r;
   endfunction

   // Scoreboard: compare every completed output handshake against the queue
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_output: got %h expected no output", bus.out_data);
         end else begin
            checkOutput("out_data", bus.out_data, expQ.pop_front());
            popCount++;
         end
      end
   end

   // Present a word and hold in_valid until accepted; optionally record
   // the expected result. Returns 1 time unit after the accept edge.
   task automatic applyStimulus(input logic [W-1:0] data, input logic [W-1:0] expWord,
                                input bit doPush);
      int waitCycles = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = data;
      while (!bus.in_ready && waitCycles < 200) begin
         @(posedge clk);
         #1;
         waitCycles++;
      end
      if (!bus.in_ready) begin
         checkOutput("accept_timeout", 64'd0, 64'd1);
      end else begin
         if (doPush) expQ.push_back(expWord);
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
   endtask

   // Count cycles from the accept edge to the first out_valid cycle
   task automatic measureLatency(output int n);
      n = 1;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic waitDrained();
      int c = 0;
      while (expQ.size() != 0 && c < 200) begin
         @(posedge clk);
         #1;
         c++;
      end
      if (expQ.size() != 0) checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);
   endtask

   // Main test sequence
   initial begin
      int lat;
      int popsBefore;
      logic [W-1:0] held;
      logic [W-1:0] rnd;

      vecs[0] = '{64'h0000000000000000, 64'hAAAAAAAAAAAAAAAA};
      vecs[1] = '{64'h0123456789ABCDEF, 64'hA39E1DF4C572680B};
      vecs[2] = '{64'hE4B179CAD20F8536, 64'h0123456789ABCDEF};
      vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hBBBBBBBBBBBBBBBB};
      vecs[4] = '{64'h1111111111111111, 64'h3333333333333333};

      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] reset state");
      checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd0);
      checkOutput("reset_out_data", bus.out_data, 64'd0);

      $display("[TB] table vectors");
      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i].inWord, vecs[i].expWord, 1'b1);
         checkOutput("run_in_ready", 64'(bus.in_ready), 64'd0);
         checkOutput("run_busy", 64'(busy), 64'd1);
         measureLatency(lat);
         checkOutput("latency", 64'(lat), 64'(NIBBLES + 1));
         waitDrained();
         #1;
      end

      $display("[TB] random round trips");
      for (int i = 0; i < 12; i++) begin
         rnd = {$urandom, $urandom};
         applyStimulus(fwdWord(rnd), rnd, 1'b1);
         waitDrained();
      end

      $display("[TB] backpressure");
      bus.out_ready = 1'b0;
      applyStimulus(64'hFEDCBA9876543210, 64'hB086275C4FD1E93A, 1'b1);
      measureLatency(lat);
      held = bus.out_data;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("bp_out_valid", 64'(bus.out_valid), 64'd1);
         checkOutput("bp_out_data", bus.out_data, held);
         checkOutput("bp_in_ready", 64'(bus.in_ready), 64'd0);
      end
      popsBefore = popCount;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_pop", 64'(popCount), 64'(popsBefore + 1));
      checkOutput("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
      checkOutput("bp_out_valid_after", 64'(bus.out_valid), 64'd0);

      $display("[TB] input held during busy");
      applyStimulus(64'h0123456789ABCDEF, 64'hA39E1DF4C572680B, 1'b1);
      popsBefore = popCount;
      applyStimulus(64'hE4B179CAD20F8536, 64'h0123456789ABCDEF, 1'b1);
      checkOutput("held_accept_order", 64'(popCount), 64'(popsBefore + 1));
      waitDrained();

      $display("[TB] reset mid-run");
      applyStimulus(64'h5A5A5A5A5A5A5A5A, 64'd0, 1'b0);
      repeat (7) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rr_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rr_out_valid", 64'(bus.out_valid), 64'd0);
      checkOutput("rr_out_data", bus.out_data, 64'd0);
      checkOutput("rr_busy", 64'(busy), 64'd0);
      repeat (25) @(posedge clk);
      #1;
      checkOutput("rr_quiet", 64'(bus.out_valid), 64'd0);
      applyStimulus(64'hFFFFFFFFFFFFFFFF, 64'hBBBBBBBBBBBBBBBB, 1'b1);
      waitDrained();

      repeat (3) @(posedge clk);
      checkOutput("queue_empty", 64'(expQ.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
